// File: rtl/imem_fetch_port.sv
// imem_fetch_port: handshaked instruction memory for the SimpleRISC fetch stage.
// Ports: clka/rsta (sync, active-high); req_* fetch request (valid/ready);
//   rsp_* fetched word, its address and out-of-range flag (valid/ready);
//   flush discards in-flight fetches; ld_* program-load write port;
//   fetch_cnt counts completed response handshakes.
// Build option: define IMEM_OUTREG_EN for a registered output stage
//   after the memory read (latency 2 instead of 1).
module imem_fetch_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH = 2**ADDR_W,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h6800_0000
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              rsp_ready,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [31:0]       fetch_cnt
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic en;
    logic upd;
    logic acc;
    logic req_oor;
    logic ld_ok;

    assign en  = !rsp_valid || rsp_ready;
    // A flush frees the pipe even under stall so the redirect gets in.
    assign upd = en || flush;
    assign req_ready = !rsta && !ld_en && upd;
    assign acc = req_valid && req_ready;
    assign req_oor = {1'b0, req_addr} >= DEPTH_L;
    assign ld_ok = ld_en && ({1'b0, ld_addr} < DEPTH_L);

    // Memory is never reset; only the load port writes it.
    always_ff @(posedge clka) begin
        if (ld_ok) begin
            mem[ld_addr] <= ld_data;
        end
    end

`ifdef IMEM_OUTREG_EN
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_err;

    always_ff @(posedge clka) begin
        if (rsta) begin
            s1_valid <= 1'b0;
            s1_data  <= NOP_WORD;
            s1_addr  <= '0;
            s1_err   <= 1'b0;
        end else if (upd) begin
            s1_valid <= acc;
            if (acc) begin
                s1_addr <= req_addr;
                s1_err  <= req_oor;
                s1_data <= req_oor ? NOP_WORD : mem[req_addr];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            rsp_valid <= 1'b0;
            rsp_data  <= NOP_WORD;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else if (upd) begin
            // The word sitting in s1 during a flush predates the redirect.
            rsp_valid <= s1_valid && !flush;
            if (flush) begin
                rsp_data <= NOP_WORD;
                rsp_err  <= 1'b0;
            end else if (s1_valid) begin
                rsp_data <= s1_data;
                rsp_addr <= s1_addr;
                rsp_err  <= s1_err;
            end
        end
    end
`else
    always_ff @(posedge clka) begin
        if (rsta) begin
            rsp_valid <= 1'b0;
            rsp_data  <= NOP_WORD;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else if (upd) begin
            // Accepted-in-flush requests land here: that is the redirect.
            rsp_valid <= acc;
            if (acc) begin
                rsp_addr <= req_addr;
                rsp_err  <= req_oor;
                rsp_data <= req_oor ? NOP_WORD : mem[req_addr];
            end else if (flush) begin
                rsp_data <= NOP_WORD;
                rsp_err  <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clka) begin
        if (rsta) begin
            fetch_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: randomized and directed bench for imem_fetch_port
// against an in-order scoreboard and a word-array memory model.
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'h6800_0000;
    localparam int DEP = 100;
`ifdef IMEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [6:0]  a;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic        req_valid = 1'b0;
    logic [6:0]  req_addr = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [6:0]  rsp_addr;
    logic        rsp_err;
    logic        rsp_ready = 1'b1;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [6:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] mm [128];
    rsp_t q[$];
    logic [6:0] hs_log[$];
    logic [31:0] cnt_exp = '0;

    always #5 clka = ~clka;

    imem_fetch_port #(
        .DATA_W(32),
        .ADDR_W(7),
        .DEPTH(DEP),
        .NOP_WORD(NOP)
    ) dut (
        .clka(clka),
        .rsta(rsta),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_addr(rsp_addr),
        .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .flush(flush),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .fetch_cnt(fetch_cnt)
    );

    function automatic rsp_t model_rd(input logic [6:0] a);
        rsp_t r;
        r.a = a;
        if (int'(a) >= DEP) begin
            r.d = NOP;
            r.e = 1'b1;
        end else begin
            r.d = mm[a];
            r.e = 1'b0;
        end
        return r;
    endfunction

    // One clock: observe handshakes before the edge, update the model,
    // then return at edge+1 with registered outputs settled.
    task automatic cyc();
        logic acc;
        logic hs;
        rsp_t e;
        #1;
        acc = req_valid && req_ready;
        hs = rsp_valid && rsp_ready;
        if (rsta) begin
            q.delete();
            cnt_exp = '0;
        end else begin
            if (hs) begin
                hs_log.push_back(rsp_addr);
                cnt_exp = cnt_exp + 32'd1;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got addr=%0d data=%h, want none",
                             rsp_addr, rsp_data);
                end else begin
                    e = q.pop_front();
                    if (rsp_addr !== e.a || rsp_data !== e.d || rsp_err !== e.e) begin
                        bad++;
                        $display("FAIL rsp_order: got a=%0d d=%h e=%b, want a=%0d d=%h e=%b",
                                 rsp_addr, rsp_data, rsp_err, e.a, e.d, e.e);
                    end
                end
            end
            if (flush) q.delete();
            if (acc) q.push_back(model_rd(req_addr));
            if (ld_en && int'(ld_addr) < DEP) mm[ld_addr] = ld_data;
        end
        @(posedge clka);
        #1;
    endtask

    task automatic idle();
        rsta = 1'b0;
        req_valid = 1'b0;
        flush = 1'b0;
        ld_en = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic do_rst();
        idle();
        rsta = 1'b1;
        req_valid = 1'b1;
        req_addr = 7'd3;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_req_ready: got %b want 0", req_ready);
        end
        cyc();
        cyc();
        rsta = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [6:0] a, input logic [31:0] d);
        req_valid = 1'b0;
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        cyc();
        ld_en = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int t = 0; t < 10 && (q.size() > 0 || rsp_valid === 1'b1); t++) cyc();
        total++;
        if (q.size() != 0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: got pending=%0d rsp_valid=%b want 0/0", q.size(), rsp_valid);
        end
    endtask

    task automatic read_one(input logic [6:0] a, output logic [31:0] d,
                            output logic e, output logic [6:0] ra);
        bit done;
        drain();
        req_valid = 1'b1;
        req_addr = a;
        done = 0;
        for (int t = 0; t < 8 && !done; t++) begin
            #1;
            done = req_ready;
            cyc();
        end
        req_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL read_accept: got no accept for addr %0d want accept", a);
        end
        done = 0;
        d = 'x;
        e = 1'bx;
        ra = 'x;
        for (int t = 0; t < 8 && !done; t++) begin
            if (rsp_valid === 1'b1) begin
                d = rsp_data;
                e = rsp_err;
                ra = rsp_addr;
                done = 1;
            end else begin
                cyc();
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL read_rsp: got no response for addr %0d want response", a);
        end else begin
            cyc();
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic e;
        logic [6:0] ra;
        load(7'd5, 32'h5555_AAAA);
        read_one(7'd5, d, e, ra);
        do_rst();
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== NOP || rsp_addr !== 7'd0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_outputs: got v=%b d=%h a=%0d e=%b want 0/%h/0/0",
                     rsp_valid, rsp_data, rsp_addr, rsp_err, NOP);
        end
        total++;
        if (fetch_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_cnt: got %0d want 0", fetch_cnt);
        end
        read_one(7'd5, d, e, ra);
        total++;
        if (d !== 32'h5555_AAAA || e !== 1'b0) begin
            bad++;
            $display("FAIL mem_survives_rst: got %h/%b want 5555aaaa/0", d, e);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) load(7'(i), 32'hA0 + 32'(i));
        do_rst();
        idle();
        for (int k = 1; k <= 4 + LAT; k++) begin
            req_valid = (k <= 4);
            req_addr = 7'(k - 1);
            if (k <= 4) begin
                #1;
                total++;
                if (req_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_ready: got %b want 1 at k=%0d", req_ready, k);
                end
            end
            cyc();
            if (k >= LAT && k - LAT <= 3) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_addr !== 7'(k - LAT) ||
                    rsp_data !== 32'hA0 + 32'(k - LAT)) begin
                    bad++;
                    $display("FAIL stream_rsp: got v=%b a=%0d d=%h want 1/%0d/%h",
                             rsp_valid, rsp_addr, rsp_data, k - LAT, 32'hA0 + 32'(k - LAT));
                end
            end
        end
        total++;
        if (fetch_cnt !== 32'd4 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_cnt: got cnt=%0d v=%b want 4/0", fetch_cnt, rsp_valid);
        end
    endtask

    task automatic test_stall();
        int nxt;
        bit seen;
        logic a;
        do_rst();
        idle();
        nxt = 0;
        seen = 0;
        for (int t = 0; t < 12 && !seen; t++) begin
            req_valid = (nxt < 4);
            req_addr = 7'(nxt);
            #1;
            a = req_valid && req_ready;
            cyc();
            if (a) nxt++;
            if (rsp_valid === 1'b1 && rsp_addr === 7'd1) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stall_setup: got no response for addr 1 want one");
        end
        hs_log.delete();
        for (int s = 0; s < 3; s++) begin
            rsp_ready = 1'b0;
            req_valid = (nxt < 4);
            req_addr = 7'(nxt);
            ld_en = (s == 1);
            ld_addr = 7'd60;
            ld_data = $urandom;
            #1;
            total++;
            if (req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready: got %b want 0", req_ready);
            end
            cyc();
            ld_en = 1'b0;
            total++;
            if (rsp_valid !== 1'b1 || rsp_addr !== 7'd1 || rsp_data !== 32'hA1) begin
                bad++;
                $display("FAIL stall_hold: got v=%b a=%0d d=%h want 1/1/a1",
                         rsp_valid, rsp_addr, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        for (int t = 0; t < 12 && hs_log.size() < 3; t++) begin
            req_valid = (nxt < 4);
            req_addr = 7'(nxt);
            #1;
            a = req_valid && req_ready;
            cyc();
            if (a) nxt++;
        end
        total++;
        if (hs_log.size() != 3 || hs_log[0] !== 7'd1 || hs_log[1] !== 7'd2 || hs_log[2] !== 7'd3) begin
            bad++;
            $display("FAIL stall_release: got %0d responses %p want 1,2,3", hs_log.size(), hs_log);
        end
        drain();
    endtask

    task automatic test_flush();
        bit seen;
        do_rst();
        idle();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 7'd2;
        cyc();
        req_addr = 7'd3;
        cyc();
        flush = 1'b1;
        req_addr = 7'd0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_ready: got %b want 1", req_ready);
        end
        cyc();
        flush = 1'b0;
        req_valid = 1'b0;
        total++;
        if (rsp_valid !== (LAT == 1)) begin
            bad++;
            $display("FAIL flush_valid: got %b want %b", rsp_valid, LAT == 1);
        end
        hs_log.delete();
        rsp_ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 6 && !seen; t++) begin
            if (rsp_valid === 1'b1) seen = 1;
            else cyc();
        end
        total++;
        if (!seen || rsp_addr !== 7'd0 || rsp_data !== 32'hA0) begin
            bad++;
            $display("FAIL flush_redirect: got v=%b a=%0d d=%h want 1/0/a0",
                     rsp_valid, rsp_addr, rsp_data);
        end
        for (int t = 0; t < 6; t++) cyc();
        total++;
        if (hs_log.size() != 1 || hs_log[0] !== 7'd0) begin
            bad++;
            $display("FAIL flush_discard: got %0d responses %p want only 0", hs_log.size(), hs_log);
        end
    endtask

    task automatic test_oor();
        logic [31:0] d;
        logic [31:0] v;
        logic e;
        logic [6:0] ra;
        read_one(7'd120, d, e, ra);
        total++;
        if (d !== NOP || e !== 1'b1 || ra !== 7'd120) begin
            bad++;
            $display("FAIL oor_read: got d=%h e=%b a=%0d want %h/1/120", d, e, ra, NOP);
        end
        ld_en = 1'b1;
        ld_addr = 7'd120;
        ld_data = $urandom;
        req_valid = 1'b1;
        req_addr = 7'd5;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL ld_blocks_req: got %b want 0", req_ready);
        end
        cyc();
        idle();
        read_one(7'd100, d, e, ra);
        total++;
        if (d !== NOP || e !== 1'b1) begin
            bad++;
            $display("FAIL oor_after_ld: got d=%h e=%b want %h/1", d, e, NOP);
        end
        read_one(7'd20, d, e, ra);
        total++;
        if (d !== mm[20] || e !== 1'b0) begin
            bad++;
            $display("FAIL alias20: got %h/%b want %h/0", d, e, mm[20]);
        end
        read_one(7'd56, d, e, ra);
        total++;
        if (d !== mm[56] || e !== 1'b0) begin
            bad++;
            $display("FAIL alias56: got %h/%b want %h/0", d, e, mm[56]);
        end
        v = $urandom;
        load(7'd99, v);
        read_one(7'd99, d, e, ra);
        total++;
        if (d !== v || e !== 1'b0) begin
            bad++;
            $display("FAIL ld_then_rd: got %h/%b want %h/0", d, e, v);
        end
    endtask

    task automatic test_random();
        bit hold;
        logic [31:0] hd;
        logic [6:0] ha;
        logic he;
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(100, 127))
                                                   : 7'($urandom_range(0, 99));
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            ld_en = ($urandom_range(0, 9) == 0);
            ld_addr = 7'($urandom_range(0, 127));
            ld_data = $urandom;
            #1;
            total++;
            if (ld_en && req_ready !== 1'b0) begin
                bad++;
                $display("FAIL rnd_ld_block: got req_ready=%b want 0", req_ready);
            end
            if (!ld_en && rsp_ready) begin
                total++;
                if (req_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_ready: got %b want 1", req_ready);
                end
            end
            hold = rsp_valid && !rsp_ready && !flush;
            hd = rsp_data;
            ha = rsp_addr;
            he = rsp_err;
            cyc();
            if (hold) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_addr !== ha || rsp_err !== he) begin
                    bad++;
                    $display("FAIL rnd_hold: got v=%b d=%h a=%0d e=%b want 1/%h/%0d/%b",
                             rsp_valid, rsp_data, rsp_addr, rsp_err, hd, ha, he);
                end
            end
            total++;
            if (fetch_cnt !== cnt_exp) begin
                bad++;
                $display("FAIL rnd_cnt: got %0d want %0d", fetch_cnt, cnt_exp);
            end
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic e;
        logic [6:0] ra;
        drain();
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        cnt_exp = 32'hFFFF_FFFF;
        total++;
        if (fetch_cnt !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_preload: got %h want ffffffff", fetch_cnt);
        end
        read_one(7'd1, d, e, ra);
        total++;
        if (fetch_cnt !== 32'd0) begin
            bad++;
            $display("FAIL wrap: got %h want 0", fetch_cnt);
        end
    endtask

    initial begin
        idle();
        @(posedge clka);
        #1;
        do_rst();
        for (int a = 0; a < DEP; a++) load(7'(a), $urandom);
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_oor();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
